// File: rtl/mbc6_flash_ctrl.sv
// mbc6_flash_ctrl: command sequencer for the MBC6 1 MB flash.
// Decodes JEDEC unlock/command writes, drives the flash image through a
// req/ack write port and overrides CPU reads with ID or status bytes.
//
// state        | meaning
// -------------+---------------------------------------------------------
// IDLE         | array read mode, waiting for AA@5555
// U1           | first unlock cycle seen
// U2           | second unlock cycle seen, waiting for command byte
// PGM_SETUP    | program command accepted, next write is address/data
// ERS_SETUP    | erase command accepted, waiting for second unlock
// EU1          | erase path, first unlock cycle seen
// EU2          | erase path, second unlock seen, waiting for 30 or 10
// AUTOSEL      | ID read mode, left only by F0
// PROGRAM      | byte write requested, waiting for mem_ack
// PROG_HOLD    | byte written, busy held for PROG_WAIT cycles
// SECT_ERASE   | filling one sector with FF, one req/ack per byte
// CHIP_ERASE   | filling the whole 1 MB with FF, one req/ack per byte
module mbc6_flash_ctrl #(
  parameter int         SECTOR_BITS = 13,
  parameter int         PROG_WAIT   = 16,
  parameter logic [7:0] MFR_ID      = 8'hC2,
  parameter logic [7:0] DEV_ID      = 8'h81
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_cpu,
  input  logic        flash_en,
  input  logic        flash_wen,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [19:0] flash_addr,
  input  logic [7:0]  cpu_di,
  input  logic [7:0]  mem_di,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  output logic [7:0]  mem_do,
  input  logic        mem_ack,
  output logic        rd_ovr,
  output logic [7:0]  rd_ovr_data,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_U1,
    S_U2,
    S_PGM_SETUP,
    S_ERS_SETUP,
    S_EU1,
    S_EU2,
    S_AUTOSEL,
    S_PROGRAM,
    S_PROG_HOLD,
    S_SECT_ERASE,
    S_CHIP_ERASE
  } state_t;

  localparam int              TMR_W     = (PROG_WAIT > 1) ? $clog2(PROG_WAIT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = (PROG_WAIT > 0) ? TMR_W'(PROG_WAIT - 1) : '0;
  localparam logic [19:0]     SECT_LAST = 20'((1 << SECTOR_BITS) - 1);
  localparam logic [19:0]     CHIP_LAST = 20'hFFFFF;

  state_t            state;
  state_t            state_nxt;
  logic              cmd_wr;
  logic              at_ua1;
  logic              at_ua2;
  logic              busy_st;
  logic              ack_hit;
  logic              go_prog;
  logic              go_sect;
  logic              go_chip;
  logic [19:0]       erase_cnt;
  logic [TMR_W-1:0]  tmr;
  logic              prog_bit7;
  logic              toggle;

  // Programming never reads back from the image, so its read data is unused here.
  logic unused_mem_di;
  assign unused_mem_di = ^mem_di;

  assign cmd_wr  = cpu_wr & ce_cpu & flash_en & flash_wen;
  assign at_ua1  = (flash_addr[15:0] == 16'h5555);
  assign at_ua2  = (flash_addr[15:0] == 16'h2AAA);
  assign ack_hit = mem_req & mem_ack;
  assign busy_st = (state == S_PROGRAM) || (state == S_PROG_HOLD) ||
                   (state == S_SECT_ERASE) || (state == S_CHIP_ERASE);

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; busy states ignore every CPU write, F0 included.
  always_comb begin
    state_nxt = state;
    go_prog   = 1'b0;
    go_sect   = 1'b0;
    go_chip   = 1'b0;
    if (busy_st) begin
      case (state)
        S_PROGRAM:   if (ack_hit) state_nxt = (PROG_WAIT == 0) ? S_IDLE : S_PROG_HOLD;
        S_PROG_HOLD: if (tmr == '0) state_nxt = S_IDLE;
        default:     if (ack_hit && (erase_cnt == '0)) state_nxt = S_IDLE;
      endcase
    end else if (!flash_en) begin
      state_nxt = S_IDLE;
    end else if (cmd_wr) begin
      if (cpu_di == 8'hF0) begin
        state_nxt = S_IDLE;
      end else begin
        case (state)
          S_IDLE: if ((cpu_di == 8'hAA) && at_ua1) state_nxt = S_U1;
          S_U1:   state_nxt = ((cpu_di == 8'h55) && at_ua2) ? S_U2 : S_IDLE;
          S_U2: begin
            if (at_ua1 && (cpu_di == 8'hA0))      state_nxt = S_PGM_SETUP;
            else if (at_ua1 && (cpu_di == 8'h80)) state_nxt = S_ERS_SETUP;
            else if (at_ua1 && (cpu_di == 8'h90)) state_nxt = S_AUTOSEL;
            else                                  state_nxt = S_IDLE;
          end
          S_PGM_SETUP: begin
            state_nxt = S_PROGRAM;
            go_prog   = 1'b1;
          end
          S_ERS_SETUP: state_nxt = ((cpu_di == 8'hAA) && at_ua1) ? S_EU1 : S_IDLE;
          S_EU1:       state_nxt = ((cpu_di == 8'h55) && at_ua2) ? S_EU2 : S_IDLE;
          S_EU2: begin
            if (cpu_di == 8'h30) begin
              state_nxt = S_SECT_ERASE;
              go_sect   = 1'b1;
            end else if ((cpu_di == 8'h10) && at_ua1) begin
              state_nxt = S_CHIP_ERASE;
              go_chip   = 1'b1;
            end else begin
              state_nxt = S_IDLE;
            end
          end
          S_AUTOSEL: state_nxt = S_AUTOSEL;
          default:   state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Write port and counters; a request keeps address/data frozen until its ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_do    <= '0;
      erase_cnt <= '0;
      tmr       <= '0;
      prog_bit7 <= 1'b0;
    end else if (go_prog) begin
      mem_req   <= 1'b1;
      mem_addr  <= flash_addr;
      mem_do    <= cpu_di;
      prog_bit7 <= cpu_di[7];
    end else if (go_sect) begin
      mem_req   <= 1'b1;
      mem_addr  <= {flash_addr[19:SECTOR_BITS], {SECTOR_BITS{1'b0}}};
      mem_do    <= 8'hFF;
      erase_cnt <= SECT_LAST;
    end else if (go_chip) begin
      mem_req   <= 1'b1;
      mem_addr  <= '0;
      mem_do    <= 8'hFF;
      erase_cnt <= CHIP_LAST;
    end else begin
      case (state)
        S_PROGRAM: begin
          if (ack_hit) begin
            mem_req <= 1'b0;
            tmr     <= TMR_LOAD;
          end
        end
        S_PROG_HOLD: begin
          if (tmr != '0) tmr <= tmr - 1'b1;
        end
        S_SECT_ERASE, S_CHIP_ERASE: begin
          // Drop req for one cycle after each ack so every byte is a fresh request.
          if (ack_hit) begin
            mem_req <= 1'b0;
            if (erase_cnt != '0) begin
              mem_addr  <= mem_addr + 20'd1;
              erase_cnt <= erase_cnt - 20'd1;
            end
          end else if (!mem_req) begin
            mem_req <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status toggle bit flips on every CPU read while an operation runs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                        toggle <= 1'b0;
    else if (busy_st && cpu_rd && ce_cpu) toggle <= ~toggle;
  end

  // Read override: ID bytes in autoselect, status polling while busy.
  always_comb begin
    rd_ovr      = 1'b0;
    rd_ovr_data = 8'hFF;
    busy        = busy_st;
    if (state == S_AUTOSEL) begin
      rd_ovr = 1'b1;
      case (flash_addr[1:0])
        2'd0:    rd_ovr_data = MFR_ID;
        2'd1:    rd_ovr_data = DEV_ID;
        default: rd_ovr_data = 8'h00;
      endcase
    end else if (busy_st) begin
      rd_ovr      = 1'b1;
      rd_ovr_data = {((state == S_PROGRAM) || (state == S_PROG_HOLD)) ? ~prog_bit7 : 1'b0,
                     toggle, 6'b00_0000};
    end
  end

endmodule

// File: tb/tb_mbc6_flash_ctrl.sv
// tb_mbc6_flash_ctrl: directed bench for the MBC6 flash sequencer.
// Expected image writes are queued when a command is issued and checked
// by a responder that acks only while the queue holds an entry.
module tb_mbc6_flash_ctrl;

  logic        clk_sys   = 1'b0;
  logic        reset_n   = 1'b1;
  logic        ce_cpu    = 1'b1;
  logic        flash_en  = 1'b1;
  logic        flash_wen = 1'b1;
  logic        cpu_wr    = 1'b0;
  logic        cpu_rd    = 1'b0;
  logic [19:0] flash_addr = '0;
  logic [7:0]  cpu_di    = '0;
  logic [7:0]  mem_di    = '0;
  logic        mem_ack   = 1'b0;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic [7:0]  mem_do;
  logic        rd_ovr;
  logic [7:0]  rd_ovr_data;
  logic        busy;

  typedef struct packed {
    logic [19:0] addr;
    logic [7:0]  data;
  } req_t;

  req_t exp_q[$];
  int   tests     = 0;
  int   fails     = 0;
  int   req_count = 0;
  int   base      = 0;
  logic exp_toggle = 1'b0;

  mbc6_flash_ctrl dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ce_cpu      (ce_cpu),
    .flash_en    (flash_en),
    .flash_wen   (flash_wen),
    .cpu_wr      (cpu_wr),
    .cpu_rd      (cpu_rd),
    .flash_addr  (flash_addr),
    .cpu_di      (cpu_di),
    .mem_di      (mem_di),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_do      (mem_do),
    .mem_ack     (mem_ack),
    .rd_ovr      (rd_ovr),
    .rd_ovr_data (rd_ovr_data),
    .busy        (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [19:0] a, input logic [7:0] d);
    req_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic cpu_write(input logic [19:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    flash_addr = a;
    cpu_di     = d;
    cpu_wr     = 1'b1;
    @(negedge clk_sys);
    cpu_wr     = 1'b0;
  endtask

  task automatic unlock();
    cpu_write(20'h05555, 8'hAA);
    cpu_write(20'h02AAA, 8'h55);
  endtask

  task automatic cpu_read(input logic [19:0] a, input string tag, input logic ovr_exp,
                          input logic [7:0] data_exp, input logic flips);
    @(negedge clk_sys);
    flash_addr = a;
    cpu_rd     = 1'b1;
    #1;
    check({tag, "_ovr"}, 32'(rd_ovr), 32'(ovr_exp));
    if (ovr_exp) check({tag, "_data"}, 32'(rd_ovr_data), 32'(data_exp));
    @(negedge clk_sys);
    cpu_rd = 1'b0;
    if (flips) exp_toggle = ~exp_toggle;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_reqs(input int target, input int max_cyc, input string tag);
    int n = 0;
    while (req_count < target && n < max_cyc) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, 32'(req_count), 32'(target));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check({tag, "_req"},  32'(mem_req),  32'd0);
    check({tag, "_busy"}, 32'(busy),     32'd0);
    check({tag, "_ovr"},  32'(rd_ovr),   32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    exp_q.delete();
    exp_toggle = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  // Image responder: checks each request against the queue and acks it.
  initial begin
    req_t e;
    forever begin
      @(negedge clk_sys);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (reset_n && mem_req && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("req_addr", 32'(mem_addr), 32'(e.addr));
        check("req_data", 32'(mem_do),   32'(e.data));
        req_count++;
        mem_ack = 1'b1;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_req",   32'(mem_req),     32'd0);
    check("rst_addr",  32'(mem_addr),    32'd0);
    check("rst_do",    32'(mem_do),      32'd0);
    check("rst_ovr",   32'(rd_ovr),      32'd0);
    check("rst_odata", 32'(rd_ovr_data), 32'hFF);
    check("rst_busy",  32'(busy),        32'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // program 3C@12345, held without ack while polling status
    unlock();
    cpu_write(20'h05555, 8'hA0);
    cpu_write(20'h12345, 8'h3C);
    #1;
    check("pgm_req",  32'(mem_req),  32'd1);
    check("pgm_addr", 32'(mem_addr), 32'h12345);
    check("pgm_do",   32'(mem_do),   32'h3C);
    check("pgm_busy", 32'(busy),     32'd1);
    cpu_read(20'h00000, "pgm_poll0", 1'b1, {1'b1, exp_toggle, 6'b0}, 1'b1);
    cpu_read(20'h00000, "pgm_poll1", 1'b1, {1'b1, exp_toggle, 6'b0}, 1'b1);
    cpu_read(20'h00000, "pgm_poll2", 1'b1, {1'b1, exp_toggle, 6'b0}, 1'b1);
    push_req(20'h12345, 8'h3C);
    n = 0;
    do begin
      @(negedge clk_sys);
      #1;
      n++;
    end while (!mem_ack && n < 50);
    check("pgm_ack_seen", 32'(mem_ack), 32'd1);
    @(posedge clk_sys);
    #1;
    check("pgm_req_drop", 32'(mem_req), 32'd0);
    repeat (15) @(posedge clk_sys);
    #1;
    check("pgm_hold_busy", 32'(busy), 32'd1);
    @(posedge clk_sys);
    #1;
    check("pgm_end_busy", 32'(busy),   32'd0);
    check("pgm_end_ovr",  32'(rd_ovr), 32'd0);

    // sector erase via 30@0A123
    base = req_count;
    for (int i = 0; i < 8192; i++) push_req(20'h0A000 + 20'(i), 8'hFF);
    unlock();
    cpu_write(20'h05555, 8'h80);
    unlock();
    cpu_write(20'h0A123, 8'h30);
    cpu_read(20'h00000, "ers_poll", 1'b1, {1'b0, exp_toggle, 6'b0}, 1'b1);
    wait_idle(20000, "sect");
    check("sect_count", 32'(req_count - base), 32'd8192);
    check("sect_qleft", 32'(exp_q.size()),     32'd0);
    check("sect_ovr",   32'(rd_ovr),           32'd0);
    check("sect_req",   32'(mem_req),          32'd0);

    // autoselect
    unlock();
    cpu_write(20'h05555, 8'h90);
    cpu_read(20'h00000, "as_mfr", 1'b1, 8'hC2, 1'b0);
    cpu_read(20'h3FF01, "as_dev", 1'b1, 8'h81, 1'b0);
    cpu_read(20'h00002, "as_x2",  1'b1, 8'h00, 1'b0);
    cpu_write(20'h02AAA, 8'h55);
    cpu_read(20'h00004, "as_stay", 1'b1, 8'hC2, 1'b0);
    cpu_write(20'h00000, 8'hF0);
    cpu_read(20'h00000, "as_exit", 1'b0, 8'h00, 1'b0);

    // broken unlock sequence
    cpu_write(20'h05555, 8'hAA);
    cpu_write(20'h02AAA, 8'h56);
    cpu_write(20'h05555, 8'hA0);
    cpu_write(20'h00100, 8'h11);
    repeat (8) @(negedge clk_sys);
    check("brk_req",  32'(mem_req), 32'd0);
    check("brk_busy", 32'(busy),    32'd0);
    check("brk_ovr",  32'(rd_ovr),  32'd0);

    // flash_en drop mid-unlock returns to IDLE
    unlock();
    @(negedge clk_sys);
    flash_en = 1'b0;
    @(negedge clk_sys);
    flash_en = 1'b1;
    cpu_write(20'h05555, 8'h90);
    #1;
    check("fen_ovr", 32'(rd_ovr), 32'd0);

    // write protection
    flash_wen = 1'b0;
    unlock();
    cpu_write(20'h05555, 8'hA0);
    cpu_write(20'h00777, 8'h3C);
    repeat (8) @(negedge clk_sys);
    check("prot_req",  32'(mem_req), 32'd0);
    check("prot_busy", 32'(busy),    32'd0);
    flash_wen = 1'b1;

    // chip erase ignores F0/AA; responder stalls it after 600 bytes
    base = req_count;
    for (int i = 0; i < 600; i++) push_req(20'(i), 8'hFF);
    unlock();
    cpu_write(20'h05555, 8'h80);
    unlock();
    cpu_write(20'h05555, 8'h10);
    wait_reqs(base + 300, 2000, "chip_half");
    cpu_write(20'h05555, 8'hF0);
    cpu_write(20'h05555, 8'hAA);
    check("chip_f0_busy", 32'(busy), 32'd1);
    wait_reqs(base + 600, 3000, "chip_run");
    repeat (4) @(negedge clk_sys);
    check("chip_stall_req",  32'(mem_req),  32'd1);
    check("chip_stall_addr", 32'(mem_addr), 32'h00258);
    check("chip_stall_do",   32'(mem_do),   32'hFF);
    check("chip_stall_busy", 32'(busy),     32'd1);
    do_reset("chip_rst");

    // reset mid sector erase
    base = req_count;
    for (int i = 0; i < 100; i++) push_req(20'h20000 + 20'(i), 8'hFF);
    unlock();
    cpu_write(20'h05555, 8'h80);
    unlock();
    cpu_write(20'h20010, 8'h30);
    wait_reqs(base + 50, 500, "srst_run");
    do_reset("sect_rst");

    // program after reset: A5 gives status bit7 = 0
    base = req_count;
    push_req(20'h80001, 8'hA5);
    unlock();
    cpu_write(20'h05555, 8'hA0);
    cpu_write(20'h80001, 8'hA5);
    cpu_read(20'h00000, "post_poll", 1'b1, {1'b0, exp_toggle, 6'b0}, 1'b1);
    wait_idle(200, "post");
    check("post_count", 32'(req_count - base), 32'd1);

    // top sector ends at FFFFF
    base = req_count;
    for (int i = 0; i < 8192; i++) push_req(20'hFE000 + 20'(i), 8'hFF);
    unlock();
    cpu_write(20'h05555, 8'h80);
    unlock();
    cpu_write(20'hFF555, 8'h30);
    wait_idle(20000, "top");
    check("top_count", 32'(req_count - base), 32'd8192);
    check("top_last",  32'(mem_addr),         32'hFFFFF);
    check("top_qleft", 32'(exp_q.size()),     32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mbc6_flash_ctrl.md
Name: mbc6_flash_ctrl

Overview:
- Command sequencer for the 1 MB flash on MBC6 (Net de Get) carts. Mapper ROM/flash windows route here when flash is selected.
- Decodes JEDEC-style unlock/command writes: program, sector erase, chip erase, autoselect, reset.
- Drives the backing store (SDRAM flash image) through a req/ack write port.
- Overrides CPU read data with ID bytes and status polling while a command is active.

Parameters:
- SECTOR_BITS, 13, log2 of sector size in bytes (8 KB sectors, 128 sectors).
- PROG_WAIT, 16, extra clk_sys cycles the busy state is held after a program write is acked.
- MFR_ID, 8'hC2, manufacturer byte returned in autoselect.
- DEV_ID, 8'h81, device byte returned in autoselect.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ce_cpu  in  1  CPU clock enable; CPU-side strobes are sampled only when high.
- flash_en  in  1  mapper flash-enable register bit.
- flash_wen  in  1  mapper flash write-enable register bit.
- cpu_wr  in  1  CPU write strobe into the selected flash window.
- cpu_rd  in  1  CPU read strobe into the selected flash window.
- flash_addr  in  20  byte address in flash: {bank[6:0], cart_addr[12:0]}.
- cpu_di  in  8  CPU write data.
- mem_di  in  8  read data from the flash image.
- mem_req  out  1  write request to the flash image; held until ack.
- mem_addr  out  20  write address.
- mem_do  out  8  write data.
- mem_ack  in  1  one-cycle write completion.
- rd_ovr  out  1  high: CPU read data comes from rd_ovr_data, not mem_di.
- rd_ovr_data  out  8  override read byte.
- busy  out  1  program or erase in progress.

Behaviour:
- Reset values: state=IDLE; mem_req=0, mem_addr=0, mem_do=0, rd_ovr=0, rd_ovr_data=8'hFF, busy=0; toggle bit=0.
- Command write: cpu_wr & ce_cpu & flash_en & flash_wen. Writes with flash_wen=0 are ignored.
- Unlock addresses compare flash_addr[15:0] only: UA1=16'h5555, UA2=16'h2AAA.
- States and transitions (non-busy states):
  - IDLE: AA@UA1 -> U1.
  - U1: 55@UA2 -> U2.
  - U2: A0@UA1 -> PGM_SETUP; 80@UA1 -> ERS_SETUP; 90@UA1 -> AUTOSEL.
  - ERS_SETUP: AA@UA1 -> EU1.
  - EU1: 55@UA2 -> EU2.
  - EU2: 30@any addr -> SECT_ERASE, erase base = flash_addr with low SECTOR_BITS cleared; 10@UA1 -> CHIP_ERASE, base 0.
  - PGM_SETUP: next write (any addr/data) -> PROGRAM with latched address and byte.
  - Any other write in U1/U2/ERS_SETUP/EU1/EU2 -> IDLE.
  - F0@any addr in any non-busy state -> IDLE.
- AUTOSEL:
  - rd_ovr=1; rd_ovr_data = MFR_ID when flash_addr[1:0]=0, DEV_ID when =1, else 8'h00.
  - Leaves only on F0.
- PROGRAM:
  - busy=1; mem_req=1, mem_addr=latched address, mem_do = latched data AND mem_di-independent value (no read-modify; the programmed byte is the latched byte).
  - On mem_ack: mem_req=0, then wait PROG_WAIT cycles -> IDLE.
- SECT_ERASE / CHIP_ERASE:
  - busy=1; address counter writes 8'hFF sequentially with one req/ack per byte.
  - Sector: 2^SECTOR_BITS bytes. Chip: 2^20 bytes.
  - Counter increments on each ack; after the ack of the last byte -> IDLE. Counter wraps inside the 20-bit space, so a sector at 0xFE000 ends at 0xFFFFF.
- Status polling while busy:
  - rd_ovr=1; rd_ovr_data[7] = ~latched_data[7] (program) or 0 (erase); [6] = toggle bit; other bits 0.
  - Toggle bit flips on each cpu_rd & ce_cpu while busy.
- Writes while busy are ignored, including F0.
- flash_en falling while not busy -> IDLE next cycle. While busy the operation completes first.
- mem_req, once asserted, holds address and data stable until mem_ack.
- rd_ovr=0 in IDLE, U1, U2, ERS_SETUP, EU1, EU2, PGM_SETUP.
- Async reset mid-erase aborts immediately; bytes already erased remain 0xFF in the image.

Test Plan:
- Program: writes AA@5555, 55@2AAA, A0@5555, 3C@0x12345 -> mem_req with mem_addr=0x12345, mem_do=0x3C. Read during busy returns bit7=1 and bit6 toggling. After ack+16 cycles busy=0 and rd_ovr=0.
- Sector erase: unlock, 80, unlock, 30@0x0A123 -> exactly 8192 requests, addresses 0x0A000..0x0BFFF, data 0xFF, then IDLE.
- Autoselect: unlock, 90@5555 -> reads @x0=0xC2, @x1=0x81, @x2=0x00. F0 -> rd_ovr=0.
- Broken sequence: AA@5555, 56@2AAA, A0@5555, 11@0x100 -> no mem_req, state IDLE.
- Protection and busy-ignore: flash_wen=0 with a full program sequence -> no mem_req. During chip erase, F0 and AA writes are ignored and the erase runs to 0xFFFFF.
- Reset: reset_n low mid sector erase -> mem_req=0 and busy=0 immediately. After release a new program sequence works.
